// File: rtl/mtm_alu_out_scheduler.sv
// Output-side scheduler for the ALU serial link: queues result frames, holds one error frame,
// and issues one frame at a time, spaced so each issue lands while the serializer is idle.
module mtm_alu_out_scheduler #(
    parameter int RES_DEPTH = 4,
    parameter int DATA_CYC  = 56,
    parameter int ERR_CYC   = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_res_valid,
    output logic        o_res_ready,
    input  logic [31:0] i_res_c,
    input  logic [7:0]  i_res_ctl,
    input  logic        i_err_valid,
    output logic        o_err_ready,
    input  logic [7:0]  i_err_ctl,
    output logic        o_err_bad,
    output logic [31:0] o_c,
    output logic [7:0]  o_ctl_out,
    output logic        o_busy,
    output logic [15:0] o_sent_cnt
);
    // state  | meaning
    // IDLE   | nothing in flight; pick error slot first, then result FIFO
    // ISSUE  | one cycle: register chosen frame onto C/CTL_out, pop its source
    // WAIT   | frame being serialized; CTL_out idle until spacing elapses

    localparam int AW     = $clog2(RES_DEPTH);
    localparam int MAXCYC = (DATA_CYC > ERR_CYC) ? DATA_CYC : ERR_CYC;
    localparam int CW     = $clog2(MAXCYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sel_err;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_mem_c   [RES_DEPTH];
    logic [6:0]    r_mem_ctl [RES_DEPTH];
    logic          r_err_full;
    logic [7:0]    r_err_code;
    logic          r_err_bad;
    logic [31:0]   r_c;
    logic [7:0]    r_ctl_out;
    logic [15:0]   r_sent_cnt;

    logic w_res_full;
    logic w_res_empty;
    logic w_push;
    logic w_err_xfer;
    logic w_err_legal;
    logic w_unused;

    assign w_res_empty = (r_wr_ptr == r_rd_ptr);
    assign w_res_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = i_res_valid & ~w_res_full;
    assign w_err_xfer  = i_err_valid & ~r_err_full;
    assign w_err_legal = (i_err_ctl == 8'hC9) || (i_err_ctl == 8'h93) || (i_err_ctl == 8'hA5);
    // Bit 7 of the result control byte is never forwarded.
    assign w_unused    = i_res_ctl[7];

    assign o_res_ready = ~w_res_full;
    assign o_err_ready = ~r_err_full;
    assign o_err_bad   = r_err_bad;
    assign o_c         = r_c;
    assign o_ctl_out   = r_ctl_out;
    assign o_sent_cnt  = r_sent_cnt;
    assign o_busy      = (r_state != S_IDLE) | ~w_res_empty | r_err_full;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_c[r_wr_ptr[AW-1:0]]   <= i_res_c;
            r_mem_ctl[r_wr_ptr[AW-1:0]] <= i_res_ctl[6:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel_err  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err_full <= 1'b0;
            r_err_code <= 8'h00;
            r_err_bad  <= 1'b0;
            r_c        <= 32'h0;
            r_ctl_out  <= 8'hFF;
            r_sent_cnt <= 16'h0;
        end else begin
            r_err_bad <= w_err_xfer & ~w_err_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_err_xfer && w_err_legal) begin
                r_err_full <= 1'b1;
                r_err_code <= i_err_ctl;
            end
            case (r_state)
                S_IDLE: begin
                    r_ctl_out <= 8'hFF;
                    if (r_err_full) begin
                        r_sel_err <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else if (!w_res_empty) begin
                        r_sel_err <= 1'b0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_sel_err) begin
                        r_c        <= 32'h0;
                        r_ctl_out  <= r_err_code;
                        r_cnt      <= CW'(ERR_CYC - 1);
                        r_err_full <= 1'b0;
                    end else begin
                        r_c       <= r_mem_c[r_rd_ptr[AW-1:0]];
                        r_ctl_out <= {1'b0, r_mem_ctl[r_rd_ptr[AW-1:0]]};
                        r_cnt     <= CW'(DATA_CYC - 1);
                        r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
                    end
                    r_sent_cnt <= r_sent_cnt + 16'd1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_ctl_out <= 8'hFF;
                    r_cnt     <= r_cnt - CW'(1);
                    // Leave one cycle early so cnt reads 1 during IDLE; issue-to-issue is then exactly *_CYC.
                    if (r_cnt == CW'(2)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_out_scheduler.sv
// Bench for mtm_alu_out_scheduler: directed scenarios plus random traffic, each cycle compared
// against a timeline model (queue + error slot + earliest-next-issue time).
module tb_mtm_alu_out_scheduler;
    localparam int DATA_CYC = 56;
    localparam int ERR_CYC  = 12;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_res_valid = 1'b0;
    logic        o_res_ready;
    logic [31:0] i_res_c = 32'h0;
    logic [7:0]  i_res_ctl = 8'h0;
    logic        i_err_valid = 1'b0;
    logic        o_err_ready;
    logic [7:0]  i_err_ctl = 8'h0;
    logic        o_err_bad;
    logic [31:0] o_c;
    logic [7:0]  o_ctl_out;
    logic        o_busy;
    logic [15:0] o_sent_cnt;

    always #5 clk = ~clk;

    mtm_alu_out_scheduler #(.RES_DEPTH(DEPTH), .DATA_CYC(DATA_CYC), .ERR_CYC(ERR_CYC)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_res_valid(i_res_valid), .o_res_ready(o_res_ready),
        .i_res_c(i_res_c), .i_res_ctl(i_res_ctl),
        .i_err_valid(i_err_valid), .o_err_ready(o_err_ready),
        .i_err_ctl(i_err_ctl), .o_err_bad(o_err_bad),
        .o_c(o_c), .o_ctl_out(o_ctl_out), .o_busy(o_busy), .o_sent_cnt(o_sent_cnt)
    );

    typedef struct {
        logic [31:0] c;
        logic [6:0]  ctl;
    } res_t;

    res_t        q[$];
    int          n_cmp = 0;
    int          n_mism = 0;
    int          cyc = 0;
    int          m_earliest = 0;
    int          m_issue_at = 0;
    bit          m_pending = 0;
    bit          m_pend_err = 0;
    bit          m_err_full = 0;
    logic [7:0]  m_err_code = 8'h0;
    bit          m_bad = 0;
    bit          m_accepted = 0;
    logic [31:0] m_c = 32'h0;
    logic [7:0]  m_ctl = 8'hFF;
    logic [15:0] m_sent = 16'h0;
    bit          m_busy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare all outputs.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rc, input logic [7:0] rctl,
                        input logic ev, input logic [7:0] ectl);
        bit   pre_rready;
        bit   pre_eready;
        res_t r;
        i_rst = rst; i_res_valid = rv; i_res_c = rc; i_res_ctl = rctl;
        i_err_valid = ev; i_err_ctl = ectl;
        pre_rready = (q.size() < DEPTH);
        pre_eready = !m_err_full;
        @(posedge clk);
        m_bad = 0;
        m_accepted = 0;
        if (rst) begin
            q.delete();
            m_err_full = 0; m_pending = 0; m_earliest = 0;
            m_c = 32'h0; m_ctl = 8'hFF; m_sent = 16'h0;
        end else begin
            m_ctl = 8'hFF;
            if (m_pending && cyc == m_issue_at) begin
                if (m_pend_err) begin
                    m_c = 32'h0; m_ctl = m_err_code; m_err_full = 0;
                    m_earliest = cyc + ERR_CYC;
                end else begin
                    r = q.pop_front();
                    m_c = r.c; m_ctl = {1'b0, r.ctl};
                    m_earliest = cyc + DATA_CYC;
                end
                m_sent = m_sent + 16'd1;
                m_pending = 0;
            end else if (!m_pending && cyc + 1 >= m_earliest && (m_err_full || q.size() > 0)) begin
                m_pending = 1; m_pend_err = m_err_full; m_issue_at = cyc + 1;
            end
            if (rv && pre_rready) begin
                r.c = rc; r.ctl = rctl[6:0];
                q.push_back(r);
                m_accepted = 1;
            end
            if (ev && pre_eready) begin
                if (ectl == 8'hC9 || ectl == 8'h93 || ectl == 8'hA5) begin
                    m_err_full = 1; m_err_code = ectl;
                end else begin
                    m_bad = 1;
                end
            end
        end
        m_busy = m_pending || (cyc < m_earliest - 2) || (q.size() > 0) || m_err_full;
        cyc++;
        #1;
        check("ctl_out",   {24'h0, o_ctl_out},  {24'h0, m_ctl});
        check("c",         o_c,                 m_c);
        check("busy",      {31'h0, o_busy},     {31'h0, m_busy});
        check("sent_cnt",  {16'h0, o_sent_cnt}, {16'h0, m_sent});
        check("res_ready", {31'h0, o_res_ready}, {31'h0, (q.size() < DEPTH)});
        check("err_ready", {31'h0, o_err_ready}, {31'h0, !m_err_full});
        check("err_bad",   {31'h0, o_err_bad},  {31'h0, m_bad});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 8'h0, 0, 8'h0);
    endtask

    initial begin
        logic [31:0] data;
        logic [7:0]  code;
        int          k;

        // Reset
        step(1, 0, 32'h0, 8'h0, 0, 8'h0);
        step(1, 0, 32'h0, 8'h0, 0, 8'h0);
        check("rst_ctl",  {24'h0, o_ctl_out}, 32'h0000_00FF);
        check("rst_busy", {31'h0, o_busy}, 32'h0);

        // Single result into an idle scheduler: visible two edges after acceptance
        step(0, 1, 32'h1234_5678, 8'h05, 0, 8'h0);
        step(0, 0, 32'h0, 8'h0, 0, 8'h0);
        step(0, 0, 32'h0, 8'h0, 0, 8'h0);
        check("s1_ctl",  {24'h0, o_ctl_out}, 32'h0000_0005);
        check("s1_c",    o_c, 32'h1234_5678);
        check("s1_sent", {16'h0, o_sent_cnt}, 32'h1);
        idle(60);

        // Three back-to-back results, bit7 stripped on the second
        step(0, 1, 32'hAAAA_0001, 8'h11, 0, 8'h0);
        step(0, 1, 32'hAAAA_0002, 8'h85, 0, 8'h0);
        step(0, 1, 32'hAAAA_0003, 8'h33, 0, 8'h0);
        idle(180);

        // Error arriving mid-frame jumps ahead of queued results
        step(0, 1, 32'hBBBB_0001, 8'h01, 0, 8'h0);
        step(0, 1, 32'hBBBB_0002, 8'h02, 0, 8'h0);
        step(0, 1, 32'hBBBB_0003, 8'h03, 0, 8'h0);
        idle(8);
        step(0, 0, 32'h0, 8'h0, 1, 8'hC9);
        idle(200);

        // Fill FIFO during WAIT; keep offering so back-pressure and push+pop are exercised
        step(0, 1, 32'hCCCC_0000, 8'h40, 0, 8'h0);
        k = 1;
        for (int i = 0; i < 130; i++) begin
            step(0, 1, 32'hCCCC_0000 + k, 8'h40 + 8'(k), 0, 8'h0);
            if (m_accepted) k++;
        end
        idle(300);

        // Illegal error code: dropped with a one-cycle err_bad pulse
        step(0, 0, 32'h0, 8'h0, 1, 8'h42);
        check("s5_bad", {31'h0, o_err_bad}, 32'h1);
        idle(3);

        // Reset mid-WAIT with results queued
        step(0, 1, 32'hDDDD_0001, 8'h01, 0, 8'h0);
        step(0, 1, 32'hDDDD_0002, 8'h02, 0, 8'h0);
        step(0, 1, 32'hDDDD_0003, 8'h03, 0, 8'h0);
        step(0, 1, 32'hDDDD_0004, 8'h04, 0, 8'h0);
        idle(15);
        step(1, 0, 32'h0, 8'h0, 0, 8'h0);
        check("s6_ctl",  {24'h0, o_ctl_out}, 32'h0000_00FF);
        check("s6_busy", {31'h0, o_busy}, 32'h0);
        check("s6_sent", {16'h0, o_sent_cnt}, 32'h0);
        idle(80);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            data = $urandom;
            case ($urandom_range(0, 3))
                0:       code = 8'hC9;
                1:       code = 8'h93;
                2:       code = 8'hA5;
                default: code = 8'($urandom);
            endcase
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) < 3), data,
                 8'($urandom), ($urandom_range(0, 29) == 0), code);
        end
        idle(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end
endmodule
